// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter driving a shared mux2 select (optional hold timeout: MUX2_ARBITER_TIMEOUT_EN)
module mux2_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int CW       = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   output logic s,
   output logic busy
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, state_n;
   logic   last;
   logic   expire;
   if (HOLD_MAX < 2 || HOLD_MAX > 255 || (1 << CW) <= HOLD_MAX) begin : g_bad_cfg
      $error("mux2_arbiter: HOLD_MAX must be 2..255 and fit in CW bits");
   end
`ifdef MUX2_ARBITER_TIMEOUT_EN
   logic [CW-1:0] cnt;
   logic          other;
   // contention detection and forced handover once the owner has had HOLD_MAX cycles
   always_comb begin
      other  = (state == OWN0) ? req1 : req0;
      expire = (state != IDLE) & other & (cnt == CW'(HOLD_MAX - 1));
   end
   // hold counter: runs only while the other side waits, clears on any ownership change
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= (state_n == state && state != IDLE && other) ? cnt + 1'b1 : '0;
`else
   // no timeout: an owner keeps the grant until it releases
   always_comb expire = 1'b0;
`endif
   // next-state: ties go to the requester that did not own last, handover needs no idle gap
   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? ((req0 & req1) ? (last ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE) :
                (state == OWN0) ? ((req0 & ~expire) ? OWN0 : req1 ? OWN1 : IDLE) :
                                  ((req1 & ~expire) ? OWN1 : req0 ? OWN0 : IDLE);
   end
   // state and registered outputs; select holds through IDLE so the mux output stays put
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         s     <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         last  <= (state_n == OWN1) ? 1'b1 : (state_n == OWN0) ? 1'b0 : last;
         gnt0  <= state_n == OWN0;
         gnt1  <= state_n == OWN1;
         s     <= (state_n == OWN1) ? 1'b1 : (state_n == OWN0) ? 1'b0 : s;
         busy  <= state_n != IDLE;
      end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: scoreboard bench for mux2_arbiter, outputs compared as {gnt0,gnt1,s,busy}
module tb_mux2_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0 = 1'b0;
   logic req1 = 1'b0;
   logic gnt0, gnt1, s, busy;
   logic [3:0] q[$];
   int total = 0;
   int passed = 0;

   mux2_arbiter #(.HOLD_MAX(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .gnt0(gnt0), .gnt1(gnt1), .s(s), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string n, input logic [3:0] a, input logic [3:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %b expected %b (gnt0 gnt1 s busy) at %0t", n, a, e, $time);
   endtask

   task automatic step(input logic r0, input logic r1, input logic [3:0] e);
      @(negedge clk);
      req0 = r0;
      req1 = r1;
      q.push_back(e);
   endtask

   // monitor: compare the registered outputs shortly after every edge
   initial forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) check("cycle", {gnt0, gnt1, s, busy}, q.pop_front());
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 check("reset_state", {gnt0, gnt1, s, busy}, 4'b0000);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 5; i++) step(0, 0, 4'b0000);
      for (int i = 0; i < 3; i++) step(1, 1, 4'b1001);
      step(0, 1, 4'b0111);
      step(0, 0, 4'b0010);
      for (int i = 0; i < 3; i++) step(0, 1, 4'b0111);
      step(0, 0, 4'b0010);
      step(0, 0, 4'b0010);
      step(1, 1, 4'b1001);
      step(0, 0, 4'b0000);
      step(1, 1, 4'b0111);
      step(0, 1, 4'b0111);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async_reset", {gnt0, gnt1, s, busy}, 4'b0000);
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 12; i++)
`ifdef MUX2_ARBITER_TIMEOUT_EN
         step(1, 1, ((i / 4) % 2 == 1) ? 4'b0111 : 4'b1001);
`else
         step(1, 1, 4'b1001);
`endif
      step(0, 0, 4'b0000);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of a mux2 shared between two sources (I0 path = requester 0, I1 path = requester 1).
- Grants exclusive use of the shared mux output to one requester at a time and drives S accordingly.
- Sits between the requesting units and the mux2 instance; fully synchronous apart from reset.

Parameters:
- HOLD_MAX, 8, max consecutive contended grant cycles per owner (used only with the optional feature); legal range 2..255.
- CW, 8, width of the hold counter; must satisfy 2**CW > HOLD_MAX.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Req0  input  1  request from source 0; held high for as long as ownership is wanted.
- Req1  input  1  request from source 1; same rules as Req0.
- Gnt0  output  1  registered grant to source 0.
- Gnt1  output  1  registered grant to source 1.
- S  output  1  registered mux select: 0 = I0 path, 1 = I1 path.
- Busy  output  1  registered; high whenever either grant is high.

Behaviour:
- States: IDLE, OWN0, OWN1. Internal Last bit = most recent owner.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state = IDLE, Gnt0 = Gnt1 = 0, S = 0, Busy = 0.
  - Last = 1, so requester 0 wins the first tie.
  - Counter = 0.
- All outputs are registered and change only on a rising Clock edge (or on Reset).
- Latency: a request sampled high at edge n gives a grant visible after edge n. There is no combinational path from Req to Gnt.
- IDLE:
  - Req0 & Req1: grant the requester that is not Last.
  - Only Req0 -> OWN0. Only Req1 -> OWN1. Neither -> stay in IDLE.
- OWN0:
  - Req0 high: stay in OWN0.
  - Req0 low and Req1 high: go directly to OWN1 (zero-gap handover, no IDLE cycle).
  - Req0 low and Req1 low: go to IDLE.
- OWN1: mirror of OWN0.
- On entering OWNx: Last = x and the counter clears.
- Output decode:
  - Gnt0 = (state == OWN0); Gnt1 = (state == OWN1). The two grants are never high together.
  - Busy = Gnt0 | Gnt1.
  - S = 0 in OWN0, 1 in OWN1. In IDLE, S holds its previous value so the mux output does not toggle.
- Without the optional feature, a grant is never preempted: an owner holding its request starves the other source indefinitely (by design).
- Requests are assumed synchronous to Clock; no internal synchronisers.

Optional Feature:
- Macro: MUX2_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - The counter increments each cycle in OWNx while the other request is high; it clears when the other request is low.
  - When the counter reaches HOLD_MAX-1 and the other request is high, the next edge forces a switch to the other OWN state, even if the owner's request is still high.
  - The counter clears on the switch. Result: each owner gets exactly HOLD_MAX grant cycles under continuous contention.
- Without the macro: no counter logic is synthesised; HOLD_MAX and CW are ignored; behaviour is pure hold-until-release.

Test Plan:
- Reset release, Req0 = Req1 = 0 for 5 cycles -> Gnt0 = Gnt1 = 0, S = 0, Busy = 0 throughout.
- From reset, Req0 and Req1 both rise at edge 1 -> Gnt0 = 1, S = 0 after edge 1. Req0 drops at edge 4 -> Gnt1 = 1, S = 1 after edge 4, with no idle cycle between grants.
- Only Req1 for 3 cycles, then drop -> Gnt1 for 3 cycles, then IDLE with S held at 1, Busy = 0.
- Tie after a source-1 grant: Req0 and Req1 rise together from IDLE with Last = 1 -> Gnt0 wins. Repeat with Last = 0 -> Gnt1 wins.
- Reset asserted asynchronously mid-OWN1 (between edges) -> Gnt1, S and Busy drop to 0 immediately, without waiting for a clock edge.
- MUX2_ARBITER_TIMEOUT_EN defined, HOLD_MAX = 4, both requests held high continuously -> grants alternate 4 cycles Gnt0, 4 cycles Gnt1, repeating. Without the macro -> Gnt0 stays high indefinitely.
